// File: rtl/booth_pkg.sv
// booth_pkg: shared constants, operand-stage record and helpers for the
// shared Booth multiplier arbiter.
package booth_pkg;

    localparam int W      = 4;
    localparam int PW     = 2 * W;
    localparam int NREQ   = 2;
    localparam int STAT_W = 16;

    // Operand stage contents: owning requester plus both operands.
    typedef struct packed {
        logic         id;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } op_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/BoothMulti.sv
// BoothMulti: combinational 4x4 signed radix-2 Booth multiplier, full
// 8-bit two's complement product.
module BoothMulti (
    input  logic signed [3:0] X,
    input  logic signed [3:0] Y,
    output logic signed [7:0] Z
);

    logic signed [7:0] xe;
    logic        [4:0] yb;

    // Scan multiplier bit pairs {Y[i], Y[i-1]}; 01 adds, 10 subtracts X<<i.
    always_comb begin
        xe = {{4{X[3]}}, X};
        yb = {Y, 1'b0};
        Z  = '0;
        for (int i = 0; i < 4; i++) begin
            case (yb[i +: 2])
                2'b01:   Z = Z + (xe <<< i);
                2'b10:   Z = Z - (xe <<< i);
                default: Z = Z;
            endcase
        end
    end

endmodule

// File: rtl/booth_mul_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant. On a tie the requester that did not
// win last time is granted; the pointer moves only when a grant is taken.
module rr_arb2
    import booth_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] elig_i,
    input  logic            upd_i,
    output logic [NREQ-1:0] grant_o
);

    logic last_q, last_d;

    // One-hot grant; a lone eligible requester always wins.
    always_comb begin
        grant_o = elig_i;
        if (elig_i == 2'b11) begin
            grant_o = last_q ? 2'b01 : 2'b10;
        end
    end

    // Remember the winner of an accepted grant.
    always_comb begin
        last_d = last_q;
        if (upd_i) begin
            last_d = grant_o[1];
        end
    end

    // Pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: two requesters share one combinational 4-bit signed
// Booth multiplier. Operands are registered in front of the multiplier and
// products are registered behind it, one result register per requester.
// Each requester may have one op outstanding until its response is taken.
// Optional feature macro BOOTH_ARB_STATS_EN adds saturating per-requester
// completion counters (stat_cnt) with a synchronous clear (stat_clr).
module booth_mul_arbiter #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*W-1:0]   req_X,
    input  logic [2*W-1:0]   req_Y,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [4*W-1:0]   resp_Z
`ifdef BOOTH_ARB_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [2*16-1:0]  stat_cnt
`endif
);

    import booth_pkg::*;

    // The shared multiplier is fixed at 4 bits.
    if (W != 4) begin : g_bad_width
        $error("booth_mul_arbiter: W must be 4");
    end

    logic [NREQ-1:0]         pending_q, pending_d;
    op_t                     op_q, op_d;
    logic                    op_valid_q, op_valid_d;
    logic [NREQ-1:0]         resp_valid_q, resp_valid_d;
    logic [NREQ-1:0][PW-1:0] res_q, res_d;

    logic [NREQ-1:0]         elig;
    logic [NREQ-1:0]         grant;
    logic [NREQ-1:0]         hs;
    logic                    accept;
    logic [PW-1:0]           z;

    // No grants while reset is held, so ready stays low during reset.
    assign elig   = req_valid & ~pending_q & {NREQ{~rst}};
    assign accept = |grant;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .elig_i  (elig),
        .upd_i   (accept),
        .grant_o (grant)
    );

    BoothMulti u_mul (
        .X (op_q.x),
        .Y (op_q.y),
        .Z (z)
    );

    assign req_ready  = grant;
    assign resp_valid = resp_valid_q;
    assign resp_Z     = res_q;
    assign hs         = resp_valid_q & resp_ready;

    // Next state: capture accepted operands, retire the operand stage into
    // its owner's result register, and track per-requester outstanding ops.
    always_comb begin
        op_d       = op_q;
        op_valid_d = accept;
        if (accept) begin
            op_d.id = grant[1];
            op_d.x  = grant[1] ? req_X[W +: W] : req_X[0 +: W];
            op_d.y  = grant[1] ? req_Y[W +: W] : req_Y[0 +: W];
        end

        pending_d    = (pending_q | grant) & ~hs;
        resp_valid_d = resp_valid_q & ~hs;
        res_d        = res_q;
        // The owner cannot hold an unconsumed result here: it is still pending.
        if (op_valid_q) begin
            res_d[op_q.id]        = z;
            resp_valid_d[op_q.id] = 1'b1;
        end
    end

    // Pipeline and handshake state; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            op_q         <= '0;
            op_valid_q   <= 1'b0;
            resp_valid_q <= '0;
            res_q        <= '0;
        end else begin
            pending_q    <= pending_d;
            op_q         <= op_d;
            op_valid_q   <= op_valid_d;
            resp_valid_q <= resp_valid_d;
            res_q        <= res_d;
        end
    end

`ifdef BOOTH_ARB_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] stat_q, stat_d;

    // Count completed response handshakes; clear wins over an increment.
    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < NREQ; i++) begin
            if (stat_clr) begin
                stat_d[i] = '0;
            end else if (hs[i]) begin
                stat_d[i] = sat_inc(stat_q[i]);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule
